// File: rtl/cpu_sequencer.sv
// Instruction sequencer: FETCH -> DECODE -> EXEC -> NEXT, trapping to HALT on illegal opcode or watchdog expiry.
// Latency: 4 cycles per instruction minimum; outputs are registered or decoded from state only.
// Backpressure: FETCH waits indefinitely for instr_valid; EXEC waits for unit_done for at most TIMEOUT cycles.
module cpu_sequencer #(
    parameter int PC_W    = 8,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic            clear,
    input  logic [15:0]     instr,
    input  logic            instr_valid,
    input  logic            unit_done,
    output logic            fetch_req,
    output logic [PC_W-1:0] pc,
    output logic [3:0]      op_code,
    output logic            dec_enable,
    output logic            busy,
    output logic            halted,
    output logic            err_illegal,
    output logic            err_timeout,
    output logic [15:0]     retired
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_NEXT,
        S_HALT
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [3:0]        op_code_q, op_code_d;
    logic [15:0]       retired_q, retired_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              err_illegal_q, err_illegal_d;
    logic              err_timeout_q, err_timeout_d;
    logic              op_legal;

    // Only the opcode field is consumed; the operand bits belong to the execution units.
    logic unused_operand;
    assign unused_operand = ^instr[11:0];

    assign op_legal = !((op_code_q >= 4'hC) && (op_code_q <= 4'hE));

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        op_code_d     = op_code_q;
        retired_d     = retired_q;
        wd_d          = wd_q;
        err_illegal_d = err_illegal_q;
        err_timeout_d = err_timeout_q;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (instr_valid) begin
                    op_code_d = instr[15:12];
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                wd_d = '0;
                if (op_legal) begin
                    state_d = S_EXEC;
                end else begin
                    err_illegal_d = 1'b1;
                    state_d       = S_HALT;
                end
            end
            S_EXEC: begin
                // unit_done takes priority over an expiring watchdog in the same cycle
                if (unit_done) begin
                    state_d = S_NEXT;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    err_timeout_d = 1'b1;
                    state_d       = S_HALT;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            S_NEXT: begin
                pc_d      = pc_q + PC_W'(1);
                retired_d = retired_q + 16'd1;
                state_d   = run ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                if (clear) begin
                    err_illegal_d = 1'b0;
                    err_timeout_d = 1'b0;
                    state_d       = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            pc_q          <= '0;
            op_code_q     <= '0;
            retired_q     <= '0;
            wd_q          <= '0;
            err_illegal_q <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            op_code_q     <= op_code_d;
            retired_q     <= retired_d;
            wd_q          <= wd_d;
            err_illegal_q <= err_illegal_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign fetch_req   = (state_q == S_FETCH);
    assign dec_enable  = (state_q == S_EXEC);
    assign busy        = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                         (state_q == S_EXEC)  || (state_q == S_NEXT);
    assign halted      = (state_q == S_HALT);
    assign pc          = pc_q;
    assign op_code     = op_code_q;
    assign retired     = retired_q;
    assign err_illegal = err_illegal_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized bench for cpu_sequencer: each instruction is described by opcode, fetch wait and exec delay,
// and a transaction-level model predicts cycle counts, pc/retired and the trap flags.
module tb_cpu_sequencer;

    localparam int PC_W    = 8;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              run = 1'b0;
    logic              clear = 1'b0;
    logic [15:0]       instr = '0;
    logic              instr_valid = 1'b0;
    logic              unit_done = 1'b0;
    logic              fetch_req;
    logic [PC_W-1:0]   pc;
    logic [3:0]        op_code;
    logic              dec_enable;
    logic              busy;
    logic              halted;
    logic              err_illegal;
    logic              err_timeout;
    logic [15:0]       retired;

    cpu_sequencer #(.PC_W(PC_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .run(run), .clear(clear), .instr(instr),
        .instr_valid(instr_valid), .unit_done(unit_done), .fetch_req(fetch_req),
        .pc(pc), .op_code(op_code), .dec_enable(dec_enable), .busy(busy),
        .halted(halted), .err_illegal(err_illegal), .err_timeout(err_timeout),
        .retired(retired)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    int m_pc = 0;
    int m_ret = 0;
    bit m_ill = 1'b0;
    bit m_to = 1'b0;

    // observations collected while an instruction is driven
    int o_fetch, o_dec, o_busy, o_halt, o_opbad, o_len;

    function automatic bit legal_op(input logic [3:0] op);
        return !(op == 4'hC || op == 4'hD || op == 4'hE);
    endfunction

    function automatic logic [3:0] rand_legal();
        int v;
        v = $urandom_range(0, 12);
        return (v == 12) ? 4'hF : 4'(v);
    endfunction

    function automatic logic [3:0] rand_illegal();
        return 4'(12 + $urandom_range(0, 2));
    endfunction

    // EXEC cycles an instruction should spend: d is the exec-cycle index carrying unit_done
    function automatic int exec_cycles(input logic [3:0] op, input int d);
        if (!legal_op(op)) return 0;
        return (d < TIMEOUT) ? d + 1 : TIMEOUT;
    endfunction

    task automatic drive_junk();
        instr       = 16'($urandom);
        instr_valid = 1'($urandom);
        unit_done   = 1'($urandom);
    endtask

    // At a negedge with the sequencer idle: request run so the next edge enters FETCH.
    task automatic start_from_idle();
        drive_junk();
        run   = 1'b1;
        clear = 1'($urandom);
        @(negedge clk);
    endtask

    // Entered at a negedge with the sequencer in FETCH. Drives one instruction by schedule:
    // fetch wait w, unit_done on exec cycle d (d >= TIMEOUT means never), run=rn_next in NEXT.
    task automatic exec_instr(input logic [3:0] op, input int w, input int d,
                              input bit rn_next, input bit drop_run);
        int e_cyc;
        bit done;
        e_cyc = exec_cycles(op, d);
        done  = legal_op(op) && (d < TIMEOUT);
        if (!legal_op(op))  o_len = w + 2;
        else if (done)      o_len = w + 3 + e_cyc;
        else                o_len = w + 2 + e_cyc;
        o_fetch = 0; o_dec = 0; o_busy = 0; o_halt = 0; o_opbad = 0;
        for (int c = 0; c < o_len; c++) begin
            o_fetch += int'(fetch_req);
            o_dec   += int'(dec_enable);
            o_busy  += int'(busy);
            o_halt  += int'(halted);
            if (dec_enable && op_code !== op) o_opbad++;
            drive_junk();
            clear = 1'($urandom);
            run   = (drop_run && c > w) ? 1'b0 : 1'($urandom);
            if (c <= w) begin
                instr_valid = (c == w);
                if (c == w) instr[15:12] = op;
            end else if (c >= w + 2 && c < w + 2 + e_cyc) begin
                unit_done = (d < TIMEOUT) && (c - w - 2 == d);
            end else if (c == w + 2 + e_cyc) begin
                run = rn_next;
            end
            @(negedge clk);
        end
        if (done) begin
            m_pc  = (m_pc + 1) % (1 << PC_W);
            m_ret = (m_ret + 1) % 65536;
        end else if (!legal_op(op)) begin
            m_ill = 1'b1;
        end else begin
            m_to = 1'b1;
        end
    endtask

    // Entered in HALT: three cycles of noise with clear low, then a clear pulse back to IDLE.
    task automatic halt_clear();
        o_halt = 0;
        repeat (3) begin
            drive_junk();
            run   = 1'($urandom);
            clear = 1'b0;
            @(negedge clk);
            o_halt += int'(halted);
        end
        run   = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        m_ill = 1'b0;
        m_to  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run   = 1'b0;
        clear = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        m_pc = 0; m_ret = 0; m_ill = 1'b0; m_to = 1'b0;
    endtask

    task automatic test_reset();
        run = 1'b1; instr_valid = 1'b1; unit_done = 1'b1; clear = 1'b1; instr = 16'($urandom);
        repeat (3) @(negedge clk);
        checks++;
        if ({fetch_req, dec_enable, busy, halted, err_illegal, err_timeout} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: fetch/dec/busy/halt/eill/eto got %b expected 000000",
                     {fetch_req, dec_enable, busy, halted, err_illegal, err_timeout});
        end
        checks++;
        if (pc !== '0 || retired !== 16'd0 || op_code !== 4'd0) begin
            errors++;
            $display("FAIL reset_regs: pc/retired/op got %0d/%0d/%0d expected 0/0/0", pc, retired, op_code);
        end
        run = 1'b0; clear = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || halted !== 1'b0 || fetch_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy/halt/fetch got %b%b%b expected 000", busy, halted, fetch_req);
        end
    endtask

    // Everything tied high: three back-to-back 4-cycle instructions.
    task automatic test_back_to_back();
        int dec_cnt, busy_cnt, bad_seq;
        dec_cnt = 0; busy_cnt = 0; bad_seq = 0;
        run = 1'b1; instr_valid = 1'b1; unit_done = 1'b1; clear = 1'b0; instr = 16'h1234;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            dec_cnt  += int'(dec_enable);
            busy_cnt += int'(busy);
            if (pc !== PC_W'(k / 4)) bad_seq++;
            if (fetch_req !== (k % 4 == 0) || dec_enable !== (k % 4 == 2)) bad_seq++;
        end
        run = 1'b0;
        @(negedge clk);
        instr_valid = 1'b0; unit_done = 1'b0;
        m_pc = 3; m_ret = 3;
        checks++;
        if (dec_cnt !== 3 || busy_cnt !== 12 || bad_seq !== 0) begin
            errors++;
            $display("FAIL b2b_timing: dec/busy/badseq got %0d/%0d/%0d expected 3/12/0", dec_cnt, busy_cnt, bad_seq);
        end
        checks++;
        if (pc !== PC_W'(m_pc) || retired !== 16'(m_ret) || busy !== 1'b0 || op_code !== 4'h1) begin
            errors++;
            $display("FAIL b2b_end: pc/ret/busy/op got %0d/%0d/%b/%0d expected 3/3/0/1", pc, retired, busy, op_code);
        end
    endtask

    task automatic test_illegal();
        logic [3:0] op;
        int w;
        op = rand_illegal();
        w  = $urandom_range(0, 3);
        start_from_idle();
        exec_instr(op, w, 0, 1'b1, 1'b0);
        checks++;
        if (o_dec !== 0 || o_fetch !== w + 1 || o_busy !== w + 2) begin
            errors++;
            $display("FAIL illegal_counts: dec/fetch/busy got %0d/%0d/%0d expected 0/%0d/%0d", o_dec, o_fetch, o_busy, w + 1, w + 2);
        end
        checks++;
        if (halted !== 1'b1 || err_illegal !== 1'b1 || err_timeout !== 1'b0 || pc !== PC_W'(m_pc)) begin
            errors++;
            $display("FAIL illegal_halt: halt/eill/eto/pc got %b/%b/%b/%0d expected 1/1/0/%0d", halted, err_illegal, err_timeout, pc, m_pc);
        end
        halt_clear();
        checks++;
        if (o_halt !== 3 || halted !== 1'b0 || busy !== 1'b0 || err_illegal !== 1'b0 || pc !== PC_W'(m_pc)) begin
            errors++;
            $display("FAIL illegal_clear: heldhalt/halt/busy/eill/pc got %0d/%b/%b/%b/%0d expected 3/0/0/0/%0d", o_halt, halted, busy, err_illegal, pc, m_pc);
        end
    endtask

    task automatic test_timeout();
        start_from_idle();
        exec_instr(4'h5, 1, TIMEOUT, 1'b0, 1'b0);
        checks++;
        if (o_dec !== TIMEOUT || halted !== 1'b1 || err_timeout !== 1'b1 || err_illegal !== 1'b0) begin
            errors++;
            $display("FAIL timeout_halt: dec/halt/eto/eill got %0d/%b/%b/%b expected %0d/1/1/0", o_dec, halted, err_timeout, err_illegal, TIMEOUT);
        end
        halt_clear();
        checks++;
        if (halted !== 1'b0 || err_timeout !== 1'b0 || pc !== PC_W'(m_pc) || retired !== 16'(m_ret)) begin
            errors++;
            $display("FAIL timeout_clear: halt/eto/pc/ret got %b/%b/%0d/%0d expected 0/0/%0d/%0d", halted, err_timeout, pc, retired, m_pc, m_ret);
        end
        start_from_idle();
        exec_instr(4'hA, 0, TIMEOUT - 1, 1'b0, 1'b0);
        checks++;
        if (o_dec !== TIMEOUT || halted !== 1'b0 || err_timeout !== 1'b0 || busy !== 1'b0 || pc !== PC_W'(m_pc)) begin
            errors++;
            $display("FAIL timeout_lastcycle: dec/halt/eto/busy/pc got %0d/%b/%b/%b/%0d expected %0d/0/0/0/%0d", o_dec, halted, err_timeout, busy, pc, TIMEOUT, m_pc);
        end
    endtask

    task automatic test_run_drop();
        start_from_idle();
        exec_instr(rand_legal(), 2, 3, 1'b0, 1'b1);
        checks++;
        if (o_dec !== 4 || busy !== 1'b0 || fetch_req !== 1'b0 || halted !== 1'b0 ||
            pc !== PC_W'(m_pc) || retired !== 16'(m_ret)) begin
            errors++;
            $display("FAIL run_drop: dec/busy/fetch/halt/pc/ret got %0d/%b/%b/%b/%0d/%0d expected 4/0/0/0/%0d/%0d", o_dec, busy, fetch_req, halted, pc, retired, m_pc, m_ret);
        end
    endtask

    task automatic test_random();
        logic [3:0] op;
        int w, d, ed;
        bit rn, eh, eb, in_fetch;
        in_fetch = 1'b0;
        for (int i = 0; i < 60; i++) begin
            op = ($urandom_range(0, 7) == 0) ? rand_illegal() : rand_legal();
            w  = $urandom_range(0, 3);
            case ($urandom_range(0, 5))
                0:       d = TIMEOUT + $urandom_range(0, 2);
                1:       d = TIMEOUT - 1 - $urandom_range(0, 1);
                default: d = $urandom_range(0, 5);
            endcase
            rn = 1'($urandom);
            if (!in_fetch) start_from_idle();
            exec_instr(op, w, d, rn, 1'b0);
            ed = exec_cycles(op, d);
            eh = !legal_op(op) || (d >= TIMEOUT);
            eb = !eh && rn;
            checks++;
            if (o_fetch !== w + 1 || o_dec !== ed || o_busy !== o_len || o_halt !== 0 || o_opbad !== 0) begin
                errors++;
                $display("FAIL rand_counts[%0d]: fetch/dec/busy/halt/opbad got %0d/%0d/%0d/%0d/%0d expected %0d/%0d/%0d/0/0",
                         i, o_fetch, o_dec, o_busy, o_halt, o_opbad, w + 1, ed, o_len);
            end
            checks++;
            if (pc !== PC_W'(m_pc) || retired !== 16'(m_ret) || halted !== eh || busy !== eb ||
                err_illegal !== m_ill || err_timeout !== m_to) begin
                errors++;
                $display("FAIL rand_state[%0d]: pc/ret/halt/busy/eill/eto got %0d/%0d/%b/%b/%b/%b expected %0d/%0d/%b/%b/%b/%b",
                         i, pc, retired, halted, busy, err_illegal, err_timeout, m_pc, m_ret, eh, eb, m_ill, m_to);
            end
            if (eh) begin
                halt_clear();
                checks++;
                if (o_halt !== 3 || halted !== 1'b0 || err_illegal !== 1'b0 || err_timeout !== 1'b0 ||
                    pc !== PC_W'(m_pc) || retired !== 16'(m_ret)) begin
                    errors++;
                    $display("FAIL rand_clear[%0d]: heldhalt/halt/eill/eto/pc/ret got %0d/%b/%b/%b/%0d/%0d expected 3/0/0/0/%0d/%0d",
                             i, o_halt, halted, err_illegal, err_timeout, pc, retired, m_pc, m_ret);
                end
                in_fetch = 1'b0;
            end else begin
                in_fetch = rn;
            end
        end
    endtask

    task automatic test_pc_wrap();
        do_reset();
        start_from_idle();
        for (int i = 0; i < 255; i++) exec_instr(rand_legal(), 0, 0, 1'b1, 1'b0);
        checks++;
        if (pc !== PC_W'(255) || retired !== 16'd255) begin
            errors++;
            $display("FAIL wrap_pre: pc/ret got %0d/%0d expected 255/255", pc, retired);
        end
        exec_instr(rand_legal(), 0, 0, 1'b0, 1'b0);
        checks++;
        if (pc !== PC_W'(m_pc) || retired !== 16'(m_ret) || m_pc != 0 || m_ret != 256) begin
            errors++;
            $display("FAIL wrap_post: pc/ret got %0d/%0d expected 0/256", pc, retired);
        end
    endtask

    task automatic test_reset_mid_exec();
        start_from_idle();
        instr = {4'h3, 12'($urandom)}; instr_valid = 1'b1; unit_done = 1'b0; run = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (dec_enable !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midexec_pre: dec/busy got %b/%b expected 1/1", dec_enable, busy);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({fetch_req, dec_enable, busy, halted, err_illegal, err_timeout} !== 6'b0 ||
            pc !== '0 || retired !== 16'd0 || op_code !== 4'd0) begin
            errors++;
            $display("FAIL midexec_async: ctrl=%b pc/ret/op got %0d/%0d/%0d expected ctrl=000000 0/0/0",
                     {fetch_req, dec_enable, busy, halted, err_illegal, err_timeout}, pc, retired, op_code);
        end
        @(negedge clk);
        run = 1'b0; unit_done = 1'b1;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        unit_done = 1'b0;
        checks++;
        if (busy !== 1'b0 || halted !== 1'b0 || pc !== '0 || retired !== 16'd0) begin
            errors++;
            $display("FAIL midexec_after: busy/halt/pc/ret got %b/%b/%0d/%0d expected 0/0/0/0", busy, halted, pc, retired);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_illegal();
        test_timeout();
        test_run_drop();
        test_random();
        test_pc_wrap();
        test_reset_mid_exec();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
